// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation linear solver.
package sar_pkg;

  // Width of every f(x), target and residual quantity.
  localparam int unsigned CMP_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTest,
    StTrim,
    StDone
  } state_e;

  // Ceiling log2, with clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((res < 32) && ((64'd1 << res) < 64'(value))) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/sar_lin_eval.sv
// Combinational evaluator of the forward model f(in) = SLOPE*in + OFFSET.
module sar_lin_eval
  import sar_pkg::*;
#(
  parameter int unsigned IN_W   = 9,
  parameter int unsigned SLOPE  = 24,
  parameter int unsigned OFFSET = 3000
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [CMP_W-1:0] f_o
);

  assign f_o = CMP_W'(SLOPE) * CMP_W'(in_i) + CMP_W'(OFFSET);

endmodule

// File: rtl/sar_linear_solver.sv
// Successive-approximation inverse of f(x) = SLOPE*x + OFFSET against T = SCALE*target_y,
// one result bit per cycle, with floor/nearest rounding, range flags and residual.
module sar_linear_solver
  import sar_pkg::*;
#(
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned SLOPE  = 24,
  parameter int unsigned OFFSET = 3000,
  parameter int unsigned SCALE  = 10,
  parameter int unsigned TOL    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             round_md,
  input  logic [Y_W-1:0]   target_y,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x,
  output logic             under,
  output logic             over,
  output logic             in_tol,
  output logic [CMP_W-1:0] resid
);

  localparam int unsigned BitW = (X_W > 1) ? clog2(X_W) : 1;
  localparam logic [X_W-1:0] XMax = {X_W{1'b1}};
  localparam longint unsigned FMaxL = 64'(SLOPE) * ((64'd1 << X_W) - 64'd1) + 64'(OFFSET);
  localparam longint unsigned TMaxL = 64'(SCALE) * ((64'd1 << Y_W) - 64'd1);
  localparam logic [CMP_W-1:0] FMax = CMP_W'(FMaxL);

  // f(max)+SLOPE and the largest target must fit below 2^31 so no compare wraps.
  if ((FMaxL + 64'(SLOPE) >= 64'h8000_0000) || (TMaxL >= 64'h8000_0000)) begin : g_bad_params
    $error("sar_linear_solver: parameters overflow the 31-bit compare range");
  end

  state_e           state_q, state_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [X_W-1:0]   xw_q, xw_d;     // working x built MSB first
  logic [CMP_W-1:0] fx_q, fx_d;     // f(xw_q), tracked so TRIM needs only one evaluator
  logic [CMP_W-1:0] t_q, t_d;
  logic             md_q, md_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [X_W-1:0]   x_q, x_d;
  logic             under_q, under_d;
  logic             over_q, over_d;
  logic             in_tol_q, in_tol_d;
  logic [CMP_W-1:0] resid_q, resid_d;

  logic [X_W-1:0]   trial;
  logic [X_W:0]     eval_in;
  logic [CMP_W-1:0] f_eval;
  logic             t_under, t_over, take_up;
  logic [X_W-1:0]   trim_x;
  logic [CMP_W-1:0] trim_resid;

  // Evaluator input: candidate bit during TEST, the upper neighbour x+1 during TRIM.
  always_comb begin
    trial   = xw_q | (X_W'(1) << bit_q);
    eval_in = (state_q == StTest) ? {1'b0, trial} : ({1'b0, xw_q} + (X_W + 1)'(1));
  end

  sar_lin_eval #(
    .IN_W   (X_W + 1),
    .SLOPE  (SLOPE),
    .OFFSET (OFFSET)
  ) u_eval (
    .in_i (eval_in),
    .f_o  (f_eval)
  );

  // Final rounding, range clamping and residual for the result being committed.
  always_comb begin
    t_under = t_q < CMP_W'(OFFSET);
    t_over  = t_q > FMax;
    // Outside the under case fx_q <= T < f(x+1), so both differences are non-negative.
    take_up = md_q && (xw_q != XMax) && ((f_eval - t_q) < (t_q - fx_q));
    if (t_under) begin
      trim_x     = '0;
      trim_resid = CMP_W'(OFFSET) - t_q;
    end else if (t_over) begin
      trim_x     = XMax;
      trim_resid = t_q - FMax;
    end else if (take_up) begin
      trim_x     = xw_q + X_W'(1);
      trim_resid = f_eval - t_q;
    end else begin
      trim_x     = xw_q;
      trim_resid = t_q - fx_q;
    end
  end

  // Next-state logic for the FSM, search datapath and result registers.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    xw_d     = xw_q;
    fx_d     = fx_q;
    t_d      = t_q;
    md_d     = md_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    x_d      = x_q;
    under_d  = under_q;
    over_d   = over_q;
    in_tol_d = in_tol_q;
    resid_d  = resid_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          busy_d  = 1'b1;
          t_d     = CMP_W'(SCALE) * CMP_W'(target_y);
          md_d    = round_md;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        state_d = StTest;
        xw_d    = '0;
        fx_d    = CMP_W'(OFFSET);
        bit_d   = BitW'(X_W - 1);
      end
      StTest: begin
        if (f_eval <= t_q) begin
          xw_d = trial;
          fx_d = f_eval;
        end
        if (bit_q == '0) begin
          state_d = StTrim;
        end else begin
          bit_d = bit_q - BitW'(1);
        end
      end
      StTrim: begin
        state_d  = StDone;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        x_d      = trim_x;
        under_d  = t_under;
        over_d   = t_over;
        resid_d  = trim_resid;
        in_tol_d = trim_resid <= CMP_W'(TOL);
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      bit_q    <= '0;
      xw_q     <= '0;
      fx_q     <= '0;
      t_q      <= '0;
      md_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      in_tol_q <= 1'b0;
      resid_q  <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      xw_q     <= xw_d;
      fx_q     <= fx_d;
      t_q      <= t_d;
      md_q     <= md_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      under_q  <= under_d;
      over_q   <= over_d;
      in_tol_q <= in_tol_d;
      resid_q  <= resid_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign x      = x_q;
  assign under  = under_q;
  assign over   = over_q;
  assign in_tol = in_tol_q;
  assign resid  = resid_q;

endmodule

// File: tb/tb_sar_linear_solver.sv
// Self-checking bench for sar_linear_solver: directed cases on the default build and a
// brute-force scoreboard on a second, wider build.
module tb_sar_linear_solver;

  typedef struct packed {
    logic [15:0] x;
    logic        under;
    logic        over;
    logic        in_tol;
    logic [31:0] resid;
  } res_t;

  logic        clk;
  logic        rst;

  logic        start_a, md_a;
  logic [9:0]  ty_a;
  logic        busy_a, done_a, under_a, over_a, in_tol_a;
  logic [7:0]  x_a;
  logic [31:0] resid_a;

  logic        start_b, md_b;
  logic [9:0]  ty_b;
  logic        busy_b, done_b, under_b, over_b, in_tol_b;
  logic [9:0]  x_b;
  logic [31:0] resid_b;

  int   n_pass;
  int   n_total;
  res_t exp_q[$];

  sar_linear_solver u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .round_md (md_a),
    .target_y (ty_a),
    .busy     (busy_a),
    .done     (done_a),
    .x        (x_a),
    .under    (under_a),
    .over     (over_a),
    .in_tol   (in_tol_a),
    .resid    (resid_a)
  );

  sar_linear_solver #(
    .X_W    (10),
    .Y_W    (10),
    .SLOPE  (7),
    .OFFSET (100),
    .SCALE  (3),
    .TOL    (12)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .round_md (md_b),
    .target_y (ty_b),
    .busy     (busy_b),
    .done     (done_b),
    .x        (x_b),
    .under    (under_b),
    .over     (over_b),
    .in_tol   (in_tol_b),
    .resid    (resid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(input int unsigned xv, input bit un, input bit ov, input bit tol,
                              input int unsigned rv);
    res_t r;
    r.x      = 16'(xv);
    r.under  = un;
    r.over   = ov;
    r.in_tol = tol;
    r.resid  = rv;
    return r;
  endfunction

  function automatic res_t obs_a();
    return mk(int'(x_a), under_a, over_a, in_tol_a, resid_a);
  endfunction

  function automatic res_t obs_b();
    return mk(int'(x_b), under_b, over_b, in_tol_b, resid_b);
  endfunction

  // Exhaustive search over every x: floor = largest f(x) <= T, nearest = smallest |f(x)-T|
  // with ties resolved to the lower x.
  function automatic res_t model(input int unsigned xw, input int unsigned slope,
                                 input int unsigned offset, input int unsigned scale,
                                 input int unsigned tol, input int unsigned ty, input bit md);
    longint unsigned t, f, fmax, d, best_d;
    longint unsigned best;
    res_t r;
    t      = longint'(scale) * longint'(ty);
    fmax   = longint'(slope) * ((64'd1 << xw) - 1) + longint'(offset);
    best   = 0;
    best_d = 64'hFFFF_FFFF_FFFF;
    for (longint unsigned i = 0; i < (64'd1 << xw); i++) begin
      f = longint'(slope) * i + longint'(offset);
      if (!md) begin
        if (f <= t) best = i;
      end else begin
        d = (f > t) ? f - t : t - f;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    f = longint'(slope) * best + longint'(offset);
    d = (f > t) ? f - t : t - f;
    r.x      = 16'(best);
    r.under  = t < longint'(offset);
    r.over   = t > fmax;
    r.in_tol = d <= longint'(tol);
    r.resid  = 32'(d);
    return r;
  endfunction

  // Pulse start on one build and wait (bounded) for done; no checking here.
  task automatic start_wait(input bit sel_b, input logic [9:0] ty, input logic md,
                            output int cyc, output bit ok);
    @(negedge clk);
    if (sel_b) begin
      start_b = 1'b1; ty_b = ty; md_b = md;
    end else begin
      start_a = 1'b1; ty_a = ty; md_a = md;
    end
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if ((sel_b ? done_b : done_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy_a, done_a, x_a, under_a, over_a, in_tol_a, resid_a} !== '0) begin
      $display("FAIL reset_a: got busy=%b done=%b x=%0d under=%b over=%b in_tol=%b resid=%0d, want all 0",
               busy_a, done_a, x_a, under_a, over_a, in_tol_a, resid_a);
    end else n_pass++;
    n_total++;
    if ({busy_b, done_b, x_b, under_b, over_b, in_tol_b, resid_b} !== '0) begin
      $display("FAIL reset_b: got busy=%b done=%b x=%0d resid=%0d, want all 0",
               busy_b, done_b, x_b, resid_b);
    end else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    res_t exp, obs;
    int   done_cyc;
    exp_q.push_back(mk(83, 0, 0, 1, 8));
    @(negedge clk);
    start_a = 1'b1; ty_a = 10'd500; md_a = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_a = 1'b0;
        n_total++;
        if (busy_a !== 1'b1) $display("FAIL busy_in_load: got %b, want 1", busy_a);
        else n_pass++;
      end
      if (c == 10) begin
        n_total++;
        if (busy_a !== 1'b1 || done_a !== 1'b0)
          $display("FAIL busy_in_trim: got busy=%b done=%b, want busy=1 done=0", busy_a, done_a);
        else n_pass++;
      end
      if (done_a === 1'b1) begin
        done_cyc = c;
        obs = obs_a();
        exp = exp_q.pop_front();
        n_total++;
        if (obs !== exp) $display("FAIL result_500_floor: got %p, want %p", obs, exp);
        else n_pass++;
        n_total++;
        if (busy_a !== 1'b0) $display("FAIL busy_in_done: got %b, want 0", busy_a);
        else n_pass++;
        break;
      end
    end
    n_total++;
    if (done_cyc != 11) $display("FAIL latency: done at cycle %0d, want 11", done_cyc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done_a !== 1'b0 || obs_a() !== mk(83, 0, 0, 1, 8))
      $display("FAIL done_pulse_hold: done=%b result %p, want done=0 and result held", done_a, obs_a());
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [9:0] tys[4] = '{10'd302, 10'd302, 10'd250, 10'd1023};
    logic       mds[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    res_t       exps[4];
    res_t       exp, obs;
    int         cyc;
    bit         ok;
    exps[0] = mk(0, 0, 0, 0, 20);
    exps[1] = mk(1, 0, 0, 1, 4);
    exps[2] = mk(0, 1, 0, 0, 500);
    exps[3] = mk(255, 0, 1, 0, 1110);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      start_wait(1'b0, tys[i], mds[i], cyc, ok);
      n_total++;
      if (!ok) begin
        $display("FAIL vector_%0d_timeout: no done within 40 cycles, want done", i);
        void'(exp_q.pop_front());
        continue;
      end else n_pass++;
      obs = obs_a();
      exp = exp_q.pop_front();
      n_total++;
      if (obs !== exp) $display("FAIL vector_%0d ty=%0d md=%b: got %p, want %p", i, tys[i], mds[i], obs, exp);
      else n_pass++;
    end
  endtask

  // start held through DONE; target changes after acceptance only affect the second run.
  task automatic test_back_to_back();
    res_t exp, obs;
    int   d1, d2, nd;
    exp_q.push_back(mk(83, 0, 0, 1, 8));
    exp_q.push_back(mk(1, 0, 0, 1, 4));
    @(negedge clk);
    start_a = 1'b1; ty_a = 10'd500; md_a = 1'b0;
    d1 = -1; d2 = -1; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ty_a = 10'd302; md_a = 1'b1;
      end
      if (done_a === 1'b1) begin
        nd++;
        if (nd == 1) d1 = c;
        else d2 = c;
        obs = obs_a();
        exp = exp_q.pop_front();
        n_total++;
        if (obs !== exp) $display("FAIL b2b_result_%0d: got %p, want %p", nd, obs, exp);
        else n_pass++;
        if (nd == 2) begin
          start_a = 1'b0;
          break;
        end
      end
    end
    start_a = 1'b0;
    n_total++;
    if (d1 != 11 || d2 - d1 != 11)
      $display("FAIL b2b_spacing: done at cycles %0d and %0d, want 11 and 22", d1, d2);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    res_t exp, obs;
    int   nd;
    exp_q.push_back(mk(83, 0, 0, 1, 8));
    @(negedge clk);
    start_a = 1'b1; ty_a = 10'd500; md_a = 1'b0;
    nd = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
      if (c == 5) begin
        start_a = 1'b1; ty_a = 10'd1023; md_a = 1'b1;
      end
      if (c == 6) start_a = 1'b0;
      if (done_a === 1'b1) begin
        nd++;
        if (nd == 1) begin
          obs = obs_a();
          exp = exp_q.pop_front();
          n_total++;
          if (obs !== exp) $display("FAIL ignore_start_result: got %p, want %p", obs, exp);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (nd != 1) $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", nd);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    res_t exp, obs;
    int   nd, cyc;
    bit   ok;
    @(negedge clk);
    start_a = 1'b1; ty_a = 10'd1023; md_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({busy_a, done_a, x_a, under_a, over_a, in_tol_a, resid_a} !== '0)
      $display("FAIL abort_clear: got busy=%b done=%b x=%0d under=%b over=%b in_tol=%b resid=%0d, want all 0",
               busy_a, done_a, x_a, under_a, over_a, in_tol_a, resid_a);
    else n_pass++;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) nd++;
    end
    n_total++;
    if (nd != 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", nd);
    else n_pass++;
    exp_q.push_back(mk(83, 0, 0, 1, 8));
    start_wait(1'b0, 10'd500, 1'b0, cyc, ok);
    n_total++;
    if (!ok || cyc != 11) $display("FAIL abort_restart_latency: ok=%b cycle=%0d, want ok=1 cycle=11", ok, cyc);
    else n_pass++;
    obs = obs_a();
    exp = exp_q.pop_front();
    n_total++;
    if (obs !== exp) $display("FAIL abort_restart_result: got %p, want %p", obs, exp);
    else n_pass++;
  endtask

  task automatic test_random();
    res_t       exp, obs;
    int         cyc, nerr;
    bit         ok;
    logic [9:0] ty;
    logic       md;
    nerr = 0;
    for (int i = 0; i < 2000; i++) begin
      ty = 10'($urandom_range(0, 1023));
      md = (i >= 1000);
      exp_q.push_back(model(10, 7, 100, 3, 12, int'(ty), md));
      start_wait(1'b1, ty, md, cyc, ok);
      exp = exp_q.pop_front();
      obs = obs_b();
      n_total++;
      if (!ok) begin
        $display("FAIL random_%0d_timeout: no done within 40 cycles, want done", i);
        nerr++;
      end else if (obs !== exp) begin
        $display("FAIL random_%0d ty=%0d md=%b: got %p, want %p", i, ty, md, obs, exp);
        nerr++;
      end else n_pass++;
      if (nerr > 20) break;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start_a = 1'b0; md_a = 1'b0; ty_a = '0;
    start_b = 1'b0; md_b = 1'b0; ty_b = '0;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
